multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main FSM of the multi-cycle MIPS core. Sequences a shared ALU/memory datapath
//  over several cycles per instruction: lw, sw, R-type (addu/subu/and/or/sltu),
//  beq, addiu, j. Sits beside the IR and drives all datapath muxes and write strobes.
//  Memory is accessed through a req/ready handshake with variable wait states.
// PARAMETERS
//  MEM_TIMEOUT  0   max mem wait cycles before fault; 0 = no timeout
//  COUNT_W      32  width of perf counters (used only with PERF_COUNTERS_EN)
// PORTS
//  clk         in   1  single clock, rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  op          in   6  IR[31:26]
//  funct       in   6  IR[5:0]
//  zero        in   1  ALU result == 0
//  mem_ready   in   1  memory completes access this cycle
//  mem_req     out  1  memory access request
//  memwrite    out  1  access is a write
//  iord        out  1  mem addr: 0 = PC, 1 = ALUOut
//  irwrite     out  1  load IR from memory read data
//  regdst      out  1  dest reg: 0 = rt, 1 = rd
//  memtoreg    out  1  write-back data: 0 = ALUOut, 1 = MDR
//  regwrite    out  1  register file write
//  alusrca     out  1  ALU A: 0 = PC, 1 = reg A
//  alusrcb     out  2  ALU B: 00 = reg B, 01 = 4, 10 = sext imm, 11 = sext imm<<2
//  pcsrc       out  2  PC next: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  pcwrite     out  1  PC load (already gated with zero for beq)
//  alucontrol  out  3  000 and, 001 or, 010 add, 011 undef, 110 sub, 111 sltu
//  fault       out  1  sticky: illegal op/funct or mem timeout
// BEHAVIOUR
//  - Moore outputs are decoded from state. Exceptions: FETCH irwrite/pcwrite and
//    BEQ pcwrite depend on mem_ready/zero. Outputs not listed for a state are 0;
//    alucontrol defaults to 010.
//  - Reset (async) -> BOOT: all outputs 0, fault 0. BOOT -> FETCH on next edge.
//    Reset mid-access abandons the transaction; mem_req drops immediately.
//  - FETCH: mem_req, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. On mem_ready:
//    irwrite=1, pcwrite=1 -> DECODE. Otherwise stay, with irwrite=0 and pcwrite=0.
//  - DECODE: alusrca=0, alusrcb=11, add (precomputes branch target). Next state:
//    100011/101011 -> MEMADR; 000000 -> RTEXEC; 000100 -> BEQ; 001001 -> ADDIEX;
//    000010 -> JUMP; any other op -> HALT, fault=1.
//  - MEMADR: alusrca=1, alusrcb=10, add -> MEMRD if op==100011, else MEMWR.
//  - MEMRD: mem_req, iord=1; wait for mem_ready -> MEMWB.
//  - MEMWB: regwrite, regdst=0, memtoreg=1 -> FETCH.
//  - MEMWR: mem_req, memwrite, iord=1; wait for mem_ready -> FETCH.
//  - RTEXEC: alusrca=1, alusrcb=00; funct 100001 add, 100011 sub, 100100 and,
//    100101 or, 101011 sltu -> RTWB. Any other funct: alucontrol 011 -> HALT, fault=1.
//  - RTWB: regwrite, regdst=1, memtoreg=0 -> FETCH.
//  - BEQ: alusrca=1, alusrcb=00, sub, pcsrc=01, pcwrite=zero -> FETCH.
//  - ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB: regwrite, regdst=0 -> FETCH.
//  - JUMP: pcsrc=10, pcwrite=1 -> FETCH.
//  - HALT: all strobes 0; stays in HALT until reset.
//  - mem_ready is ignored whenever mem_req=0.
//  - Zero-wait latency in cycles: lw 5, sw/R/addiu 4, beq/j 3.
//    Each mem wait state adds 1.
//  - Wait counter: cleared on entry to any mem state. With MEM_TIMEOUT=N>0, the
//    N-th consecutive wait cycle without ready -> HALT, fault=1.
// CONFIGURATION
//  PERF_COUNTERS_EN defined: adds outputs cycle_count[COUNT_W-1:0] and
//    instr_count[COUNT_W-1:0]. Both reset to 0 and wrap modulo 2^COUNT_W.
//    cycle_count increments in every state except BOOT and HALT.
//    instr_count increments on every transition into FETCH from a non-BOOT state.
//  PERF_COUNTERS_EN undefined: these ports and registers do not exist.
// STRUCTURE
//  Package mips_ctrl_pkg holds: state enum, ALU_* codes, OP_*/FUNCT_* opcodes,
//    ALUSRCB_* and PCSRC_* encodings. The package is shared with the ALU and
//    datapath.
//  Sub-module alu_funct_decode (funct -> alucontrol, valid) is combinational and
//    instantiated once.
// TESTING
//  lw op=100011, mem_ready=1 -> BOOT,FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH;
//    regwrite&memtoreg only in MEMWB.
//  beq op=000100: zero=1 -> pcwrite=1, pcsrc=01, alucontrol=110; zero=0 -> pcwrite=0.
//  FETCH with mem_ready=0 for 3 cycles -> mem_req held 4 cycles;
//    irwrite=pcwrite=1 only in the 4th.
//  R funct=101011 -> alucontrol=111, then RTWB regdst=1;
//    funct=000000 -> HALT, fault=1, strobes stay 0.
//  MEM_TIMEOUT=4, ready stuck 0 in MEMRD -> HALT after 4 cycles;
//    reset_n low mid-MEMWR -> mem_req=0 immediately.
//  PERF_COUNTERS_EN: addiu, j, sw with zero wait -> instr_count=3, cycle_count=11.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS controller, ALU and datapath.
//   Holds the controller state enum, ALU operation codes, opcode/funct values,
//   ALU B-source and PC-source mux encodings, and a helper that flags the
//   states that hold a memory request.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEXEC,
        S_RTWB,
        S_BEQ,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_UNDEF = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLTU  = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_state(state_t s);
        return s inside {S_FETCH, S_MEMRD, S_MEMWR};
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath/memory signal bundle.
//   master (controller): inputs op, funct, zero, mem_ready; outputs mem_req,
//     memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
//     pcsrc, pcwrite, alucontrol, fault (+ cycle_count, instr_count).
//   slave (datapath/memory): the mirror image.
//   PERF_COUNTERS_EN adds COUNT_W and the two perf counter signals.
interface multicycle_controller_if
`ifdef PERF_COUNTERS_EN
    #(parameter int COUNT_W = 32)
`endif
    ;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic [2:0] alucontrol;
    logic       fault;
`ifdef PERF_COUNTERS_EN
    logic [COUNT_W-1:0] cycle_count;
    logic [COUNT_W-1:0] instr_count;
    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcwrite, alucontrol, fault,
               cycle_count, instr_count
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcwrite, alucontrol, fault,
               cycle_count, instr_count
    );
`else
    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcwrite, alucontrol, fault
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcwrite, alucontrol, fault
    );
`endif
endinterface

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: maps an R-type funct field to an ALU operation.
//   funct      in  6  IR[5:0]
//   alucontrol out 3  ALU code, ALU_UNDEF for unsupported funct
//   valid      out 1  funct is one of addu/subu/and/or/sltu
module alu_funct_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       valid
);
    always_comb begin
        alucontrol = funct == FUNCT_ADDU ? ALU_ADD  :
                     funct == FUNCT_SUBU ? ALU_SUB  :
                     funct == FUNCT_AND  ? ALU_AND  :
                     funct == FUNCT_OR   ? ALU_OR   :
                     funct == FUNCT_SLTU ? ALU_SLTU : ALU_UNDEF;
        valid = alucontrol != ALU_UNDEF;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM of the multi-cycle MIPS core.
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset (forces BOOT)
//   bus      multicycle_controller_if.master: IR fields, ALU zero, memory
//            handshake in; datapath mux selects, write strobes, fault out.
//   MEM_TIMEOUT: wait cycles before a stalled memory access faults (0 = never).
//   PERF_COUNTERS_EN: adds COUNT_W and the cycle_count/instr_count counters.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
`ifdef PERF_COUNTERS_EN
    , parameter int COUNT_W = 32
`endif
) (
    input logic clk,
    input logic reset_n,
    multicycle_controller_if.master bus
);
    state_t      state;
    state_t      state_next;
    logic        fault;
    logic [31:0] wait_cnt;
    logic        timeout;
    logic [2:0]  rt_alu;
    logic        rt_valid;

    alu_funct_decode u_funct (
        .funct      (bus.funct),
        .alucontrol (rt_alu),
        .valid      (rt_valid)
    );

    // Only meaningful in a memory state while mem_ready is low.
    assign timeout = MEM_TIMEOUT > 0 && wait_cnt == 32'(MEM_TIMEOUT - 1);

    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:   state_next = S_FETCH;
            S_FETCH:  state_next = bus.mem_ready ? S_DECODE : timeout ? S_HALT : S_FETCH;
            S_DECODE: state_next = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                                   bus.op == OP_RTYPE ? S_RTEXEC :
                                   bus.op == OP_BEQ   ? S_BEQ    :
                                   bus.op == OP_ADDIU ? S_ADDIEX :
                                   bus.op == OP_J     ? S_JUMP   : S_HALT;
            S_MEMADR: state_next = bus.op == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : timeout ? S_HALT : S_MEMRD;
            S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : timeout ? S_HALT : S_MEMWR;
            S_RTEXEC: state_next = rt_valid ? S_RTWB : S_HALT;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_RTWB, S_BEQ, S_ADDIWB, S_JUMP: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = ALUSRCB_REG;
        bus.pcsrc      = PCSRC_ALU;
        bus.pcwrite    = 1'b0;
        bus.alucontrol = ALU_ADD;
        bus.fault      = fault;
        case (state)
            S_BOOT:   bus.alucontrol = 3'b000;
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = ALUSRCB_FOUR;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            // Branch target is precomputed here while the opcode is decoded.
            S_DECODE: bus.alusrcb = ALUSRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            S_RTEXEC: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = rt_alu;
            end
            S_RTWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            S_BEQ: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = ALU_SUB;
                bus.pcsrc      = PCSRC_ALUOUT;
                bus.pcwrite    = bus.zero;
            end
            S_ADDIWB: bus.regwrite = 1'b1;
            S_JUMP: begin
                bus.pcsrc   = PCSRC_JUMP;
                bus.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PERF_COUNTERS_EN
    logic [COUNT_W-1:0] cycle_count;
    logic [COUNT_W-1:0] instr_count;
    assign bus.cycle_count = cycle_count;
    assign bus.instr_count = instr_count;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_BOOT;
            fault    <= 1'b0;
            wait_cnt <= '0;
`ifdef PERF_COUNTERS_EN
            cycle_count <= '0;
            instr_count <= '0;
`endif
        end else begin
            state    <= state_next;
            fault    <= fault | (state_next == S_HALT);
            // Any state change clears the counter, so each memory state starts from 0.
            wait_cnt <= state_next != state ? '0 :
                        is_mem_state(state) && !bus.mem_ready ? wait_cnt + 32'd1 : wait_cnt;
`ifdef PERF_COUNTERS_EN
            cycle_count <= cycle_count + COUNT_W'(state != S_BOOT && state != S_HALT);
            instr_count <= instr_count + COUNT_W'(state_next == S_FETCH && state != S_FETCH && state != S_BOOT);
`endif
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller (MEM_TIMEOUT=4).
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // {mem_req,memwrite,iord,irwrite, regdst,memtoreg,regwrite,alusrca, alusrcb, pcsrc, pcwrite, alucontrol, fault}
    localparam logic [16:0] E_BOOT  = 17'b0;
    localparam logic [16:0] E_FWAIT = {4'b1000, 4'b0000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_FRDY  = {4'b1001, 4'b0000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0};
    localparam logic [16:0] E_DEC   = {4'b0000, 4'b0000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_MADR  = {4'b0000, 4'b0001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_MRD   = {4'b1010, 4'b0000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_MWB   = {4'b0000, 4'b0110, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_MWR   = {4'b1110, 4'b0000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_RTS   = {4'b0000, 4'b0001, 2'b00, 2'b00, 1'b0, 3'b111, 1'b0};
    localparam logic [16:0] E_RTBAD = {4'b0000, 4'b0001, 2'b00, 2'b00, 1'b0, 3'b011, 1'b0};
    localparam logic [16:0] E_RTWB  = {4'b0000, 4'b1010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_BEQ1  = {4'b0000, 4'b0001, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0};
    localparam logic [16:0] E_BEQ0  = {4'b0000, 4'b0001, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0};
    localparam logic [16:0] E_AWB   = {4'b0000, 4'b0010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [16:0] E_JMP   = {4'b0000, 4'b0000, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0};
    localparam logic [16:0] E_HALT  = {4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDIU = 6'b001001, J = 6'b000010;

    typedef struct {
        logic [16:0] e;
        string       n;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [16:0] act;

    // Inputs change 1 time unit after the rising edge; expectation is for the cycle just begun.
    task automatic cyc(input logic rn, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input logic [16:0] e, input string n);
        @(posedge clk);
        #1;
        reset_n = rn;
        bus.op = o;
        bus.funct = f;
        bus.zero = z;
        bus.mem_ready = r;
        q.push_back('{e, n});
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            cur = q.pop_front();
            act = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.regdst, bus.memtoreg,
                   bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcwrite,
                   bus.alucontrol, bus.fault};
            checks++;
            if (act !== cur.e) begin
                failures++;
                $display("FAIL %s got=%b exp=%b", cur.n, act, cur.e);
            end
        end
    end

    initial begin
        bus.op = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        cyc(0, RT, 6'd0, 0, 0, E_BOOT, "reset");
        cyc(1, RT, 6'd0, 0, 1, E_BOOT, "boot");
        // addiu, j, sw with zero wait
        cyc(1, ADDIU, 6'd0, 0, 1, E_FRDY, "addiu_fetch");
        cyc(1, ADDIU, 6'd0, 0, 1, E_DEC,  "addiu_decode");
        cyc(1, ADDIU, 6'd0, 0, 1, E_MADR, "addiu_ex");
        cyc(1, ADDIU, 6'd0, 0, 0, E_AWB,  "addiu_wb");
        cyc(1, J, 6'd0, 0, 1, E_FRDY, "j_fetch");
        cyc(1, J, 6'd0, 0, 0, E_DEC,  "j_decode");
        cyc(1, J, 6'd0, 0, 1, E_JMP,  "j_jump");
        cyc(1, SW, 6'd0, 0, 1, E_FRDY, "sw_fetch");
        cyc(1, SW, 6'd0, 0, 1, E_DEC,  "sw_decode");
        cyc(1, SW, 6'd0, 0, 0, E_MADR, "sw_memadr");
        cyc(1, SW, 6'd0, 0, 1, E_MWR,  "sw_memwr");
        cyc(1, LW, 6'd0, 0, 1, E_FRDY, "lw_fetch");
`ifdef PERF_COUNTERS_EN
        @(negedge clk);
        checks++;
        if (bus.instr_count !== 32'd3) begin
            failures++;
            $display("FAIL instr_count got=%0d exp=3", bus.instr_count);
        end
        checks++;
        if (bus.cycle_count !== 32'd11) begin
            failures++;
            $display("FAIL cycle_count got=%0d exp=11", bus.cycle_count);
        end
`endif
        cyc(1, LW, 6'd0, 0, 1, E_DEC,  "lw_decode");
        cyc(1, LW, 6'd0, 0, 1, E_MADR, "lw_memadr");
        cyc(1, LW, 6'd0, 0, 1, E_MRD,  "lw_memrd");
        cyc(1, LW, 6'd0, 0, 1, E_MWB,  "lw_memwb");
        // fetch with three wait states, then sltu
        for (int i = 0; i < 3; i++) cyc(1, RT, 6'b101011, 0, 0, E_FWAIT, "fetch_wait");
        cyc(1, RT, 6'b101011, 0, 1, E_FRDY, "fetch_ready");
        cyc(1, RT, 6'b101011, 0, 0, E_DEC,  "rt_decode");
        cyc(1, RT, 6'b101011, 0, 0, E_RTS,  "rt_sltu");
        cyc(1, RT, 6'b101011, 0, 0, E_RTWB, "rt_wb");
        // beq taken / not taken
        cyc(1, BEQ, 6'd0, 1, 1, E_FRDY, "beq1_fetch");
        cyc(1, BEQ, 6'd0, 1, 0, E_DEC,  "beq1_decode");
        cyc(1, BEQ, 6'd0, 1, 0, E_BEQ1, "beq_taken");
        cyc(1, BEQ, 6'd0, 0, 1, E_FRDY, "beq0_fetch");
        cyc(1, BEQ, 6'd0, 0, 0, E_DEC,  "beq0_decode");
        cyc(1, BEQ, 6'd0, 0, 0, E_BEQ0, "beq_not_taken");
        // sw with one wait state
        cyc(1, SW, 6'd0, 0, 1, E_FRDY, "swq_fetch");
        cyc(1, SW, 6'd0, 0, 0, E_DEC,  "swq_decode");
        cyc(1, SW, 6'd0, 0, 0, E_MADR, "swq_memadr");
        cyc(1, SW, 6'd0, 0, 0, E_MWR,  "swq_wait");
        cyc(1, SW, 6'd0, 0, 1, E_MWR,  "swq_done");
        // lw with memory stuck: fourth wait cycle times out
        cyc(1, LW, 6'd0, 0, 1, E_FRDY, "lwt_fetch");
        cyc(1, LW, 6'd0, 0, 0, E_DEC,  "lwt_decode");
        cyc(1, LW, 6'd0, 0, 0, E_MADR, "lwt_memadr");
        for (int i = 0; i < 4; i++) cyc(1, LW, 6'd0, 0, 0, E_MRD, "lwt_wait");
        cyc(1, LW, 6'd0, 0, 1, E_HALT, "timeout_halt");
        cyc(1, LW, 6'd0, 0, 1, E_HALT, "halt_stays");
        cyc(0, LW, 6'd0, 0, 0, E_BOOT, "reset_from_halt");
        cyc(1, SW, 6'd0, 0, 0, E_BOOT, "boot2");
        // reset asserted in the middle of a write access
        cyc(1, SW, 6'd0, 0, 1, E_FRDY, "swr_fetch");
        cyc(1, SW, 6'd0, 0, 0, E_DEC,  "swr_decode");
        cyc(1, SW, 6'd0, 0, 0, E_MADR, "swr_memadr");
        cyc(1, SW, 6'd0, 0, 0, E_MWR,  "swr_wait");
        cyc(0, SW, 6'd0, 0, 0, E_BOOT, "reset_mid_memwr");
        cyc(1, RT, 6'd0, 0, 0, E_BOOT, "boot3");
        // illegal funct
        cyc(1, RT, 6'd0, 0, 1, E_FRDY,  "badf_fetch");
        cyc(1, RT, 6'd0, 0, 0, E_DEC,   "badf_decode");
        cyc(1, RT, 6'd0, 0, 0, E_RTBAD, "badf_rtexec");
        cyc(1, RT, 6'd0, 1, 1, E_HALT,  "badf_halt");
        cyc(1, RT, 6'd0, 1, 1, E_HALT,  "badf_halt_stays");
        cyc(0, RT, 6'd0, 0, 0, E_BOOT,  "reset4");
        cyc(1, 6'b111111, 6'd0, 0, 0, E_BOOT, "boot4");
        // illegal opcode
        cyc(1, 6'b111111, 6'd0, 0, 1, E_FRDY, "bado_fetch");
        cyc(1, 6'b111111, 6'd0, 0, 0, E_DEC,  "bado_decode");
        cyc(1, 6'b111111, 6'd0, 0, 1, E_HALT, "bado_halt");
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
